// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory handshake with wait timeout and writeback register
// Optional build macro: MEM_ALIGN_CHECK_EN rejects memory ops whose address bits [2:0] are nonzero.
`ifndef WORD
`define WORD [31:0]
`endif

module mem_stage #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ex_valid,
   input  logic `WORD ex_ALUOut,
   input  logic `WORD ex_w_data,
   input  logic [4:0] ex_rd,
   input  logic       ex_MemRead,
   input  logic       ex_MemWrite,
   input  logic       ex_RegWrite,
   input  logic       ex_MemtoReg,
   output logic       mem_stall,
   output logic       dm_req,
   output logic       dm_we,
   output logic `WORD dm_addr,
   output logic `WORD dm_wdata,
   input  logic       dm_ack,
   input  logic `WORD dm_rdata,
   output logic       wb_valid,
   output logic       wb_RegWrite,
   output logic [4:0] wb_rd,
   output logic `WORD wb_data,
   output logic       bus_err
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // Count value reached on the last WAIT cycle before the request is abandoned
   localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   // Request latched on entry to WAIT; held stable on the memory bus until ack/timeout
   logic `WORD addr_q, addr_d;
   logic `WORD wdata_q, wdata_d;
   logic [4:0] rd_q, rd_d;
   logic       we_q, we_d;
   logic       rw_q, rw_d;
   logic       m2r_q, m2r_d;

   logic       wb_valid_q, wb_valid_d;
   logic       wb_rw_q, wb_rw_d;
   logic [4:0] wb_rd_q, wb_rd_d;
   logic `WORD wb_data_q, wb_data_d;
   logic       bus_err_q, bus_err_d;

   logic       is_mem;
   logic       misaligned;

   assign is_mem = ex_MemRead | ex_MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
   assign misaligned = |ex_ALUOut[2:0];
`else
   assign misaligned = 1'b0;
`endif

   // State and datapath registers; reset clears everything so the bus goes quiet at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         we_q       <= 1'b0;
         rw_q       <= 1'b0;
         m2r_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rw_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         we_q       <= we_d;
         rw_q       <= rw_d;
         m2r_q      <= m2r_d;
         wb_valid_q <= wb_valid_d;
         wb_rw_q    <= wb_rw_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         bus_err_q  <= bus_err_d;
      end
   end

   // Next-state logic: issue/bypass in IDLE, ack-or-timeout resolution in WAIT (ack has priority)
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      we_d       = we_q;
      rw_d       = rw_q;
      m2r_d      = m2r_q;
      wb_valid_d = 1'b0;
      wb_rw_d    = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      bus_err_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  wb_rw_d    = ex_RegWrite;
                  wb_rd_d    = ex_rd;
                  wb_data_d  = ex_ALUOut;
               end else if (misaligned) begin
                  bus_err_d = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = '0;
                  addr_d  = ex_ALUOut;
                  wdata_d = ex_w_data;
                  rd_d    = ex_rd;
                  we_d    = ex_MemWrite;
                  rw_d    = ex_RegWrite;
                  m2r_d   = ex_MemtoReg;
               end
            end
         end
         WAIT: begin
            if (dm_ack) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_rw_d    = rw_q & ~we_q;
               wb_rd_d    = rd_q;
               wb_data_d  = m2r_q ? dm_rdata : addr_q;
            end else if (cnt_q == LAST_CNT) begin
               state_d   = IDLE;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_stall   = (state_q == WAIT);
   assign dm_req      = (state_q == WAIT);
   assign dm_we       = (state_q == WAIT) & we_q;
   assign dm_addr     = addr_q;
   assign dm_wdata    = wdata_q;
   assign wb_valid    = wb_valid_q;
   assign wb_RegWrite = wb_rw_q;
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
`timescale 1ns/1ps

module tb_mem_stage;

   localparam int MAX_WAIT = 16;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        rw;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [31:0] ex_ALUOut;
   logic [31:0] ex_w_data;
   logic [4:0]  ex_rd;
   logic        ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg;
   logic        mem_stall, dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        wb_valid, wb_RegWrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        bus_err;

   int n_checks = 0;
   int n_fails  = 0;
   wb_t exp_q[$];

   mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_ALUOut(ex_ALUOut), .ex_w_data(ex_w_data), .ex_rd(ex_rd),
      .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
      .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
      .mem_stall(mem_stall), .dm_req(dm_req), .dm_we(dm_we),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   // Scoreboard: every writeback pulse must match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n === 1'b1 && wb_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL wb_unexpected: got wb_valid=1 data=%h rd=%0d, required no writeback", wb_data, wb_rd);
         end else begin
            automatic wb_t e = exp_q.pop_front();
            if (wb_data !== e.data || wb_rd !== e.rd || wb_RegWrite !== e.rw) begin
               n_fails++;
               $display("FAIL wb_content: got data=%h rd=%0d rw=%b, required data=%h rd=%0d rw=%b",
                        wb_data, wb_rd, wb_RegWrite, e.data, e.rd, e.rw);
            end
         end
      end
   end

   task automatic drive_clear();
      ex_valid = 0; ex_ALUOut = 0; ex_w_data = 0; ex_rd = 0;
      ex_MemRead = 0; ex_MemWrite = 0; ex_RegWrite = 0; ex_MemtoReg = 0;
   endtask

   task automatic drive_op(input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                           input logic mr, input logic mw, input logic rw, input logic m2r);
      ex_valid = 1; ex_ALUOut = a; ex_w_data = wd; ex_rd = rd;
      ex_MemRead = mr; ex_MemWrite = mw; ex_RegWrite = rw; ex_MemtoReg = m2r;
   endtask

   task automatic test_reset();
      rst_n = 0; dm_ack = 0; dm_rdata = 0;
      drive_clear();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({mem_stall, dm_req, dm_we, wb_valid, wb_RegWrite, bus_err} !== 6'b0) begin
         n_fails++;
         $display("FAIL reset_ctrl: got %b, required 000000",
                  {mem_stall, dm_req, dm_we, wb_valid, wb_RegWrite, bus_err});
      end
      n_checks++;
      if (dm_addr !== 32'd0 || dm_wdata !== 32'd0 || wb_data !== 32'd0 || wb_rd !== 5'd0) begin
         n_fails++;
         $display("FAIL reset_data: got addr=%h wdata=%h wb_data=%h wb_rd=%0d, required all 0",
                  dm_addr, dm_wdata, wb_data, wb_rd);
      end
      rst_n = 1;
   endtask

   task automatic test_alu();
      @(posedge clk); #1;
      drive_op(32'd28, 32'd0, 5'd10, 0, 0, 1, 0);
      exp_q.push_back('{32'd28, 5'd10, 1'b1});
      @(posedge clk); #1;
      drive_clear();
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b1 || dm_req !== 1'b0 || mem_stall !== 1'b0) begin
         n_fails++;
         $display("FAIL alu_issue: got wb_valid=%b dm_req=%b stall=%b, required 1 0 0", wb_valid, dm_req, mem_stall);
      end
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL alu_pulse: got wb_valid=%b, required 0", wb_valid);
      end
   endtask

   task automatic test_load();
      @(posedge clk); #1;
      drive_op(32'd86, 32'd0, 5'd9, 1, 0, 1, 1);
      exp_q.push_back('{32'h1234, 5'd9, 1'b1});
      @(posedge clk); #1;
      // An unrelated ALU op presented during WAIT must be ignored
      drive_op(32'hdead_beef, 32'd0, 5'd1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (mem_stall !== 1'b1 || dm_req !== 1'b1 || dm_we !== 1'b0 || dm_addr !== 32'd86 || wb_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL load_wait%0d: got stall=%b req=%b we=%b addr=%0d wb_valid=%b, required 1 1 0 86 0",
                     i, mem_stall, dm_req, dm_we, dm_addr, wb_valid);
         end
         if (i == 2) begin
            drive_clear();
            dm_ack = 1; dm_rdata = 32'h1234;
         end
      end
      @(posedge clk); #1;
      dm_ack = 0; dm_rdata = 0;
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b1 || dm_req !== 1'b0 || mem_stall !== 1'b0 || bus_err !== 1'b0) begin
         n_fails++;
         $display("FAIL load_done: got wb_valid=%b req=%b stall=%b err=%b, required 1 0 0 0",
                  wb_valid, dm_req, mem_stall, bus_err);
      end
   endtask

   task automatic test_store();
      @(posedge clk); #1;
      drive_op(32'd118, 32'd5, 5'd3, 0, 1, 1, 0);
      exp_q.push_back('{32'd118, 5'd3, 1'b0});
      @(posedge clk); #1;
      drive_clear();
      @(negedge clk);
      n_checks++;
      if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_wdata !== 32'd5 || dm_addr !== 32'd118) begin
         n_fails++;
         $display("FAIL store_req: got req=%b we=%b wdata=%0d addr=%0d, required 1 1 5 118",
                  dm_req, dm_we, dm_wdata, dm_addr);
      end
      dm_ack = 1;
      @(posedge clk); #1;
      dm_ack = 0;
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b1 || wb_RegWrite !== 1'b0 || dm_req !== 1'b0) begin
         n_fails++;
         $display("FAIL store_done: got wb_valid=%b rw=%b req=%b, required 1 0 0", wb_valid, wb_RegWrite, dm_req);
      end
   endtask

   task automatic test_read_write_both();
      @(posedge clk); #1;
      drive_op(32'h200, 32'ha5a5, 5'd7, 1, 1, 1, 1);
      exp_q.push_back('{32'hcafe, 5'd7, 1'b0});
      @(posedge clk); #1;
      drive_clear();
      @(negedge clk);
      n_checks++;
      if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_wdata !== 32'ha5a5) begin
         n_fails++;
         $display("FAIL both_is_write: got req=%b we=%b wdata=%h, required 1 1 a5a5", dm_req, dm_we, dm_wdata);
      end
      dm_ack = 1; dm_rdata = 32'hcafe;
      @(posedge clk); #1;
      dm_ack = 0; dm_rdata = 0;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      int err_cnt = 0;
      int drop_idx = -1;
      int err_idx = -1;
      @(posedge clk); #1;
      drive_op(32'h80, 32'd0, 5'd6, 1, 0, 1, 1);
      @(posedge clk); #1;
      drive_clear();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (dm_req === 1'b1) req_cycles++;
         else if (drop_idx < 0) drop_idx = i;
         if (bus_err === 1'b1) begin
            err_cnt++;
            err_idx = i;
         end
      end
      n_checks++;
      if (req_cycles != MAX_WAIT || drop_idx != MAX_WAIT) begin
         n_fails++;
         $display("FAIL timeout_len: got %0d req cycles (drop at %0d), required %0d", req_cycles, drop_idx, MAX_WAIT);
      end
      n_checks++;
      if (err_cnt != 1 || err_idx != MAX_WAIT) begin
         n_fails++;
         $display("FAIL timeout_err: got %0d bus_err pulses (last at %0d), required 1 at %0d", err_cnt, err_idx, MAX_WAIT);
      end
      // A stray ack while IDLE must not produce a writeback
      dm_ack = 1; dm_rdata = 32'h5555;
      @(posedge clk); #1;
      dm_ack = 0; dm_rdata = 0;
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
         n_fails++;
         $display("FAIL idle_ack: got wb_valid=%b stall=%b, required 0 0", wb_valid, mem_stall);
      end
   endtask

   task automatic test_ack_at_limit();
      @(posedge clk); #1;
      drive_op(32'h90, 32'd0, 5'd12, 1, 0, 1, 1);
      @(posedge clk); #1;
      drive_clear();
      for (int i = 0; i < MAX_WAIT; i++) begin
         @(negedge clk);
         if (i == MAX_WAIT - 1) begin
            dm_ack = 1; dm_rdata = 32'h77;
            exp_q.push_back('{32'h77, 5'd12, 1'b1});
         end
      end
      @(posedge clk); #1;
      dm_ack = 0; dm_rdata = 0;
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b1 || bus_err !== 1'b0 || dm_req !== 1'b0) begin
         n_fails++;
         $display("FAIL ack_wins: got wb_valid=%b err=%b req=%b, required 1 0 0", wb_valid, bus_err, dm_req);
      end
   endtask

   task automatic test_reset_in_wait();
      @(posedge clk); #1;
      drive_op(32'h100, 32'd0, 5'd4, 1, 0, 1, 1);
      @(posedge clk); #1;
      drive_clear();
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (mem_stall !== 1'b1) begin
         n_fails++;
         $display("FAIL rstwait_pre: got stall=%b, required 1", mem_stall);
      end
      rst_n = 0;
      #1;
      n_checks++;
      if ({mem_stall, dm_req, dm_we, wb_valid, bus_err} !== 5'b0 || dm_addr !== 32'd0 || wb_data !== 32'd0) begin
         n_fails++;
         $display("FAIL rstwait_async: got ctrl=%b addr=%h wb_data=%h, required 0",
                  {mem_stall, dm_req, dm_we, wb_valid, bus_err}, dm_addr, wb_data);
      end
      dm_ack = 1; dm_rdata = 32'h99;
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) begin
            dm_ack = 0; dm_rdata = 0;
         end
         n_checks++;
         if (wb_valid !== 1'b0 || bus_err !== 1'b0 || dm_req !== 1'b0) begin
            n_fails++;
            $display("FAIL rstwait_after%0d: got wb_valid=%b err=%b req=%b, required 0 0 0", i, wb_valid, bus_err, dm_req);
         end
      end
   endtask

   task automatic test_align();
      @(posedge clk); #1;
      drive_op(32'h44, 32'd0, 5'd2, 1, 0, 1, 1);
`ifdef MEM_ALIGN_CHECK_EN
      @(posedge clk); #1;
      drive_clear();
      @(negedge clk);
      n_checks++;
      if (dm_req !== 1'b0 || mem_stall !== 1'b0 || bus_err !== 1'b1 || wb_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL align_reject: got req=%b stall=%b err=%b wb_valid=%b, required 0 0 1 0",
                  dm_req, mem_stall, bus_err, wb_valid);
      end
      @(negedge clk);
      n_checks++;
      if (bus_err !== 1'b0) begin
         n_fails++;
         $display("FAIL align_pulse: got err=%b, required 0", bus_err);
      end
`else
      exp_q.push_back('{32'h55, 5'd2, 1'b1});
      @(posedge clk); #1;
      drive_clear();
      @(negedge clk);
      n_checks++;
      if (dm_req !== 1'b1 || dm_addr !== 32'h44 || bus_err !== 1'b0) begin
         n_fails++;
         $display("FAIL align_normal: got req=%b addr=%h err=%b, required 1 44 0", dm_req, dm_addr, bus_err);
      end
      dm_ack = 1; dm_rdata = 32'h55;
      @(posedge clk); #1;
      dm_ack = 0; dm_rdata = 0;
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b1) begin
         n_fails++;
         $display("FAIL align_wb: got wb_valid=%b, required 1", wb_valid);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i < 3) begin
            v = $urandom;
            drive_op(v, 32'd0, 5'(i + 1), 0, 0, (i != 1), 0);
            exp_q.push_back('{v, 5'(i + 1), (i != 1)});
         end else begin
            drive_clear();
         end
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            if (wb_valid !== 1'b1 || mem_stall !== 1'b0) begin
               n_fails++;
               $display("FAIL b2b_%0d: got wb_valid=%b stall=%b, required 1 0", i, wb_valid, mem_stall);
            end
         end
      end
      @(negedge clk);
      n_checks++;
      if (wb_valid !== 1'b0) begin
         n_fails++;
         $display("FAIL b2b_end: got wb_valid=%b, required 0", wb_valid);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_read_write_both();
      test_timeout();
      test_ack_at_limit();
      test_reset_in_wait();
      test_align();
      test_back_to_back();
      repeat (2) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL scoreboard_drain: got %0d pending writebacks, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter MAX_WAIT, default 16, is the number of WAIT cycles without dm_ack before a memory request is aborted (legal range 2..255).
REQ-002 clk  input  1  pipeline clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ex_valid  input  1  EX stage presents a valid instruction this cycle.
REQ-005 ex_ALUOut  input  `WORD  ALU result from EX: effective address for memory ops, writeback value otherwise.
REQ-006 ex_w_data  input  `WORD  store data (register read data 2).
REQ-007 ex_rd  input  5  destination register index.
REQ-008 ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg  input  1 each  control bits from the control unit.
REQ-009 mem_stall  output  1  upstream shall hold all ex_* inputs while this is high.
REQ-010 dm_req / dm_we  output  1 each  data-memory request, write enable.
REQ-011 dm_addr / dm_wdata  output  `WORD each  memory address, store data.
REQ-012 dm_ack  input  1  memory completes the outstanding request this cycle.
REQ-013 dm_rdata  input  `WORD  load data, valid when dm_ack is high.
REQ-014 wb_valid, wb_RegWrite  output  1 each  writeback valid, register write enable.
REQ-015 wb_rd  output  5 / wb_data  output  `WORD  writeback register index and value.
REQ-016 bus_err  output  1  one-cycle pulse on request timeout (or misalignment, see Configuration).

Function
REQ-017 The FSM shall have two states, IDLE and WAIT.
REQ-018 IDLE, ex_valid=1, MemRead=MemWrite=0: at the next edge wb_valid=1, wb_data=ex_ALUOut, wb_rd=ex_rd, wb_RegWrite=ex_RegWrite (1-cycle latency).
REQ-019 IDLE, ex_valid=1, MemRead or MemWrite=1: at the next edge the block latches address, data, rd and controls, enters WAIT, and drives dm_req=1, dm_we=MemWrite, with dm_addr/dm_wdata from the latch; wb_valid=0 that cycle.
REQ-020 MemRead=MemWrite=1 together shall be treated as a write.
REQ-021 mem_stall shall equal (state==WAIT), combinationally; ex_* inputs are ignored in WAIT.
REQ-022 In WAIT, dm_req, dm_we, dm_addr and dm_wdata shall stay stable until the edge at which dm_ack is sampled high.
REQ-023 On that ack edge: return to IDLE; dm_req=0; wb_valid=1; wb_rd is the latched rd; wb_RegWrite is the latched RegWrite AND NOT write; wb_data is dm_rdata if latched MemtoReg, else the latched address.
REQ-024 A wait counter shall clear on entry to WAIT and increment each WAIT cycle without ack.
REQ-025 When the counter reaches MAX_WAIT without ack: return to IDLE, drop dm_req, pulse bus_err for one cycle, keep wb_valid=0.
REQ-026 dm_ack in IDLE shall be ignored.
REQ-027 If ack and the timeout condition occur in the same cycle, the ack wins.
REQ-028 wb_valid shall be a one-cycle pulse per retired instruction; with ex_valid=0 in IDLE, wb_valid=0 next cycle.

Reset
REQ-029 rst_n low shall immediately force IDLE, wait counter=0, and dm_req, dm_we, mem_stall, wb_valid, wb_RegWrite, bus_err=0, with dm_addr, dm_wdata, wb_data, wb_rd=0.
REQ-030 Reset during WAIT shall abandon the request with no writeback and no bus_err; a later dm_ack shall be ignored.

Configuration
REQ-031 With MEM_ALIGN_CHECK_EN defined, a memory op in IDLE whose ex_ALUOut[2:0]!=0 shall not enter WAIT and shall not assert dm_req; next cycle bus_err=1 and wb_valid=0.
REQ-032 Without MEM_ALIGN_CHECK_EN, address bits [2:0] are not checked and all memory ops follow REQ-019.

Verification
REQ-033 ALU op: ex_ALUOut=28, rd=10, RegWrite=1 -> next cycle wb_valid=1, wb_data=28, wb_rd=10, no dm_req.
REQ-034 Load: addr=86, MemRead=MemtoReg=RegWrite=1, rd=9; dm_ack after 3 WAIT cycles with dm_rdata=0x1234 -> mem_stall high 3 cycles, addr 86 stable, then wb_data=0x1234, wb_rd=9.
REQ-035 Store: addr=118, w_data=5, MemWrite=1; ack after 1 cycle -> dm_we=1, dm_wdata=5, wb_valid=1, wb_RegWrite=0.
REQ-036 No ack, MAX_WAIT=16 -> dm_req deasserts after 16 WAIT cycles, bus_err pulses once, wb_valid stays 0.
REQ-037 rst_n low in the 2nd WAIT cycle, then ack -> outputs zero immediately, no wb_valid or bus_err afterwards.
REQ-038 MEM_ALIGN_CHECK_EN defined, load addr=0x44 -> no dm_req, bus_err=1 next cycle; undefined -> normal request to 0x44.
